// File: rtl/mcu_el2_lsu_ecc_scrub_if.sv
// Bus bundle between the LSU R-stage / DCCM write-port arbiter and the
// ECC scrub correction queue. The LSU side uses the master modport and
// the scrub queue uses the slave modport.
interface mcu_el2_lsu_ecc_scrub_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ECC_W  = 7
);
    logic              sec_valid;
    logic [ADDR_W-1:0] sec_addr;
    logic [DATA_W-1:0] sec_data;
    logic [ECC_W-1:0]  sec_ecc;
    logic              ecc_disable;
    logic              port_busy;
    logic              scrub_wr_en;
    logic [ADDR_W-1:0] scrub_wr_addr;
    logic [DATA_W-1:0] scrub_wr_data;
    logic [ECC_W-1:0]  scrub_wr_ecc;
    logic              scrub_full;
    logic              scrub_prio;
    logic              scrub_drop;

    modport master (
        output sec_valid, sec_addr, sec_data, sec_ecc, ecc_disable, port_busy,
        input  scrub_wr_en, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc,
        input  scrub_full, scrub_prio, scrub_drop
    );

    modport slave (
        input  sec_valid, sec_addr, sec_data, sec_ecc, ecc_disable, port_busy,
        output scrub_wr_en, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc,
        output scrub_full, scrub_prio, scrub_drop
    );
endinterface

// File: rtl/mcu_el2_lsu_ecc_scrub.sv
// DCCM ECC scrub correction queue. Single-bit corrected loads are queued
// (coalescing by address) and written back to the DCCM whenever the write
// port is free. A starvation FSM raises scrub_prio after STARVE_LIM blocked
// cycles. Optional macro MCU_LSU_ECC_SCRUB_CNT_EN adds scrub_cnt, a
// saturating count of accepted corrections.
module mcu_el2_lsu_ecc_scrub #(
    parameter int DEPTH      = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int ECC_W      = 7,
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic rst,
    mcu_el2_lsu_ecc_scrub_if.slave bus
`ifdef MCU_LSU_ECC_SCRUB_CNT_EN
    ,
    output logic [15:0] scrub_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_PRIO = 2'd2
    } state_t;

    // Circular queue storage
    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [ECC_W-1:0]  ecc_r  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    state_t            state_r;
    state_t            state_nx_s;
    logic [7:0]        starve_r;
    logic [7:0]        starve_nx_s;

    logic              head_valid_s;
    logic              push_s;
    logic              pop_s;
    logic [DEPTH-1:0]  match_s;
    logic [PTR_W-1:0]  match_idx_s;
    logic              coalesce_s;
    logic              alloc_s;
    logic              drop_s;
    logic              full_s;
    logic [CNT_W-1:0]  count_nx_s;

    // Pointer advance with explicit modulo-DEPTH wrap
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Push/pop decode and address-coalesce search; the popping head is
    // excluded from matching so a re-corrected address gets a fresh entry
    always_comb begin
        head_valid_s = valid_r[rd_ptr_r];
        push_s       = bus.sec_valid & ~bus.ecc_disable;
        pop_s        = head_valid_s & ~bus.port_busy & ~rst;
        match_idx_s  = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i]  = valid_r[i] & (addr_r[i] == bus.sec_addr)
                          & ~(pop_s & (PTR_W'(i) == rd_ptr_r));
            match_idx_s = match_idx_s | (match_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
        end
        full_s     = (count_r == CNT_W'(DEPTH));
        coalesce_s = push_s & (|match_s);
        alloc_s    = push_s & ~(|match_s) & (~full_s | pop_s);
        drop_s     = push_s & ~(|match_s) & full_s & ~pop_s & ~rst;
        count_nx_s = count_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
    end

    // Queue storage, pointers and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= ptr_inc(rd_ptr_r);
            end
            if (alloc_s) begin
                valid_r[wr_ptr_r] <= 1'b1;
                addr_r[wr_ptr_r]  <= bus.sec_addr;
                data_r[wr_ptr_r]  <= bus.sec_data;
                ecc_r[wr_ptr_r]   <= bus.sec_ecc;
                wr_ptr_r          <= ptr_inc(wr_ptr_r);
            end else if (coalesce_s) begin
                data_r[match_idx_s] <= bus.sec_data;
                ecc_r[match_idx_s]  <= bus.sec_ecc;
            end
            count_r <= count_nx_s;
        end
    end

    // Starvation FSM state and blocked-cycle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            starve_r <= 8'd0;
        end else begin
            state_r  <= state_nx_s;
            starve_r <= starve_nx_s;
        end
    end

    // Starvation FSM next-state: count blocked head cycles, escalate at limit
    always_comb begin
        state_nx_s  = state_r;
        starve_nx_s = starve_r;
        case (state_r)
            ST_IDLE: begin
                starve_nx_s = 8'd0;
                if (alloc_s) begin
                    state_nx_s = ST_PEND;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (pop_s) begin
                    starve_nx_s = 8'd0;
                    state_nx_s  = (count_nx_s == {CNT_W{1'b0}}) ? ST_IDLE : ST_PEND;
                end else if (head_valid_s & bus.port_busy) begin
                    starve_nx_s = starve_r + 8'd1;
                    state_nx_s  = (starve_r + 8'd1 == 8'(STARVE_LIM)) ? ST_PRIO : ST_PEND;
                end else begin
                    state_nx_s = ST_PEND;
                end
            end
            ST_PRIO: begin
                if (pop_s) begin
                    starve_nx_s = 8'd0;
                    state_nx_s  = (count_nx_s == {CNT_W{1'b0}}) ? ST_IDLE : ST_PEND;
                end else begin
                    state_nx_s = ST_PRIO;
                end
            end
            default: begin
                state_nx_s  = ST_IDLE;
                starve_nx_s = 8'd0;
            end
        endcase
    end

    assign bus.scrub_wr_en   = pop_s;
    assign bus.scrub_wr_addr = head_valid_s ? addr_r[rd_ptr_r] : {ADDR_W{1'b0}};
    assign bus.scrub_wr_data = head_valid_s ? data_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign bus.scrub_wr_ecc  = head_valid_s ? ecc_r[rd_ptr_r]  : {ECC_W{1'b0}};
    assign bus.scrub_full    = full_s;
    assign bus.scrub_prio    = (state_r == ST_PRIO);
    assign bus.scrub_drop    = drop_s;

`ifdef MCU_LSU_ECC_SCRUB_CNT_EN
    logic        accept_s;
    logic [15:0] scrub_cnt_r;

    assign accept_s = (coalesce_s | alloc_s) & ~rst;

    // Saturating count of accepted (coalesced or allocated) corrections
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_cnt_r <= 16'd0;
        end else if (accept_s && (scrub_cnt_r != 16'hFFFF)) begin
            scrub_cnt_r <= scrub_cnt_r + 16'd1;
        end
    end

    assign scrub_cnt = scrub_cnt_r;
`endif

endmodule

// File: tb/tb_mcu_el2_lsu_ecc_scrub.sv
// Scoreboard bench for mcu_el2_lsu_ecc_scrub: a queue-level reference model
// predicts writes, drops, full and priority; a negedge monitor compares.
module tb_mcu_el2_lsu_ecc_scrub;
    localparam int DEPTH = 2;
    localparam int LIM   = 8;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [6:0]  e;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef MCU_LSU_ECC_SCRUB_CNT_EN
    logic [15:0] scrub_cnt;
`endif

    mcu_el2_lsu_ecc_scrub_if #(.ADDR_W(16), .DATA_W(32), .ECC_W(7)) bus ();

    mcu_el2_lsu_ecc_scrub #(
        .DEPTH(DEPTH), .ADDR_W(16), .DATA_W(32), .ECC_W(7), .STARVE_LIM(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MCU_LSU_ECC_SCRUB_CNT_EN
        ,
        .scrub_cnt(scrub_cnt)
`endif
    );

    always #5 clk = ~clk;

    ent_t mq[$];      // model of pending corrections, head first
    ent_t exp_q[$];   // scoreboard of expected DCCM writes
    int   blk = 0;    // consecutive blocked cycles of the current head
    int   mcnt = 0;   // model accepted-correction count (saturating)
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    logic exp_wr, exp_full, exp_prio, exp_drop, exp_empty;
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model
    task automatic step(input logic v, input logic [15:0] a, input logic [31:0] d,
                        input logic [6:0] e, input logic dis, input logic busy,
                        input logic r);
        bit   pop;
        bit   hit;
        ent_t t;
        @(posedge clk);
        #1;
        bus.sec_valid   = v;
        bus.sec_addr    = a;
        bus.sec_data    = d;
        bus.sec_ecc     = e;
        bus.ecc_disable = dis;
        bus.port_busy   = busy;
        rst             = r;
        exp_full  = (mq.size() == DEPTH);
        exp_prio  = (blk >= LIM);
        exp_empty = (mq.size() == 0);
        exp_cnt   = 16'(mcnt);
        exp_drop  = 1'b0;
        if (r) begin
            exp_wr = 1'b0;
            mq.delete();
            blk  = 0;
            mcnt = 0;
        end else begin
            pop    = (mq.size() > 0) && !busy;
            exp_wr = pop;
            if (pop) exp_q.push_back(mq[0]);
            if (v && !dis) begin
                hit = 1'b0;
                for (int i = (pop ? 1 : 0); i < mq.size(); i++) begin
                    if (mq[i].a == a) begin
                        t = mq[i]; t.d = d; t.e = e; mq[i] = t;
                        hit = 1'b1;
                    end
                end
                if (hit) begin
                    if (mcnt < 65535) mcnt++;
                end else if (mq.size() - (pop ? 1 : 0) < DEPTH) begin
                    t.a = a; t.d = d; t.e = e;
                    mq.push_back(t);
                    if (mcnt < 65535) mcnt++;
                end else begin
                    exp_drop = 1'b1;
                end
            end
            if (pop) begin
                void'(mq.pop_front());
                blk = 0;
            end else if (!exp_empty && busy && blk < LIM) begin
                blk++;
            end
        end
    endtask

    task automatic idle(input logic busy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 32'h0, 7'h0, 1'b0, busy, 1'b0);
    endtask

    // Monitor: compare DUT outputs against model expectations mid-cycle
    initial begin
        ent_t w;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("wr_en", 64'(bus.scrub_wr_en), 64'(exp_wr));
                chk("full",  64'(bus.scrub_full),  64'(exp_full));
                chk("prio",  64'(bus.scrub_prio),  64'(exp_prio));
                chk("drop",  64'(bus.scrub_drop),  64'(exp_drop));
`ifdef MCU_LSU_ECC_SCRUB_CNT_EN
                chk("cnt", 64'(scrub_cnt), 64'(exp_cnt));
`endif
                if (exp_empty) begin
                    chk("empty_addr", 64'(bus.scrub_wr_addr), 64'h0);
                    chk("empty_data", 64'(bus.scrub_wr_data), 64'h0);
                    chk("empty_ecc",  64'(bus.scrub_wr_ecc),  64'h0);
                end
                if (bus.scrub_wr_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("wr_unexpected", 64'(1), 64'(0));
                    end else begin
                        w = exp_q.pop_front();
                        chk("wr_addr", 64'(bus.scrub_wr_addr), 64'(w.a));
                        chk("wr_data", 64'(bus.scrub_wr_data), 64'(w.d));
                        chk("wr_ecc",  64'(bus.scrub_wr_ecc),  64'(w.e));
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        bus.sec_valid = 1'b0; bus.sec_addr = 16'h0; bus.sec_data = 32'h0;
        bus.sec_ecc = 7'h0; bus.ecc_disable = 1'b0; bus.port_busy = 1'b0;
        @(posedge clk);
        step(1'b0, 16'h0, 32'h0, 7'h0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        idle(1'b0, 2);

        // single correction written the next cycle
        step(1'b1, 16'h0040, 32'hDEADBEEF, 7'h5A, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 3);

        // fill, overflow drop, in-order drain
        step(1'b1, 16'h0010, 32'h11111111, 7'h11, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0020, 32'h22222222, 7'h22, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0030, 32'h33333333, 7'h33, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1);
        idle(1'b0, 3);

        // coalesce two corrections of the same word
        step(1'b1, 16'h0100, 32'h00000001, 7'h01, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0100, 32'h00000002, 7'h02, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);
        idle(1'b0, 3);

        // starvation priority and release
        step(1'b1, 16'h0200, 32'hCAFEF00D, 7'h3C, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 11);
        idle(1'b0, 3);

        // push and pop while full, then reset with two entries pending
        step(1'b1, 16'h0300, 32'hA0A0A0A0, 7'h0A, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0304, 32'hB0B0B0B0, 7'h0B, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0308, 32'hC0C0C0C0, 7'h0C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h030C, 32'hD0D0D0D0, 7'h0D, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 32'h0, 7'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 3);

        // ecc_disable blocks pushes but not draining
        step(1'b1, 16'h0400, 32'h12345678, 7'h12, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0404, 32'h9ABCDEF0, 7'h34, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h0408, 32'h0F0F0F0F, 7'h56, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 2);

        // randomized traffic over a small address set to exercise coalescing
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)),
                 16'h0800 + 16'($urandom_range(0, 3)) * 16'h4,
                 32'($urandom), 7'($urandom_range(0, 127)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) == 0));
        end
        idle(1'b0, 4);

`ifdef MCU_LSU_ECC_SCRUB_CNT_EN
        // counter saturation: 0xFFFF + 3 accepted (coalesced) corrections
        step(1'b0, 16'h0, 32'h0, 7'h0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 65538; n++) begin
            step(1'b1, 16'h0A00, 32'(n), 7'h1, 1'b0, 1'b1, 1'b0);
        end
        idle(1'b0, 2);
        chk("cnt_sat", 64'(scrub_cnt), 64'hFFFF);
`endif

        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
